serializador_bits: RTL and testbench
====================================

# serializador_bits

Byte-to-bit serializer that sits directly upstream of the sequence detector. It accepts bytes over a valid/ready handshake into a small FIFO and shifts each byte out MSB-first, one bit per clock. It produces the serial `bit_out` stream plus a one-cycle `inicio` pulse on the first bit of every contiguous burst, suitable for driving the detector's `bit_in`/`start` inputs.

## Interface
- `PROFUNDIDADE`, default 4: FIFO depth in bytes; must be a power of 2, minimum 2.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `dado_in`  in  8  byte to serialize.
- `dado_valido`  in  1  `dado_in` is valid this cycle.
- `pronto`  out  1  FIFO can accept a byte (combinational, = FIFO not full).
- `bit_out`  out  1  current serial bit (registered).
- `bit_valido`  out  1  `bit_out` is valid this cycle (registered).
- `inicio`  out  1  high for exactly the cycle carrying the first bit of a burst (registered).
- `ocupacao`  out  log2(PROFUNDIDADE)+1  bytes currently held in the FIFO, excluding the byte in the shifter.

## Operation
- **Reset** (any time, asynchronous): FIFO emptied, pointers and `ocupacao` = 0, state = OCIOSO, shift register = 0, bit counter = 0.
  - Outputs during and after reset: `bit_out`=0, `bit_valido`=0, `inicio`=0, `pronto`=1.
  - Writes presented while `rst` is high are discarded.
- **Push**: the byte is written at the edge where `dado_valido && pronto`. When the FIFO is full, `pronto`=0 and `dado_valido` is ignored; the byte is not written.
- **State machine**, two states:
  - OCIOSO, FIFO non-empty: pop the head byte into the shift register and set `bit_out`<=byte[7], `bit_valido`<=1, `inicio`<=1, counter<=7. Go to DESLOCA.
  - OCIOSO, FIFO empty: `bit_valido`<=0, `inicio`<=0.
  - DESLOCA, counter ≠ 0: shift left, `bit_out`<=next bit, counter decrements, `inicio`<=0.
  - DESLOCA, counter = 0 (last bit currently on output), FIFO non-empty: pop the next byte back-to-back. `bit_out`<=new[7], counter<=7, `inicio` stays 0, stay in DESLOCA.
  - DESLOCA, counter = 0, FIFO empty: `bit_valido`<=0, `bit_out`<=0, go to OCIOSO.
- **No bypass**: a byte pushed into an empty FIFO is popped no earlier than the next edge.
- **Simultaneous push and pop** on the same edge:
  - Allowed whenever `pronto`=1.
  - `ocupacao` is unchanged.
  - Data order is preserved.
- **FIFO pointers**: wrap modulo PROFUNDIDADE. Full/empty are derived from `ocupacao`.

## Timing
- **Latency**: byte accepted at edge N with FIFO empty and state OCIOSO → first bit valid after edge N+1.
- **Byte duration**: each byte occupies exactly 8 consecutive `bit_valido` cycles.
- **Back-to-back bytes**: no gap between bytes if the next byte is in the FIFO by the edge at which the last bit of the current byte is on the output.
- **`inicio` width**: `inicio` is never high for more than one cycle. It is high only when `bit_valido` is high.
- **`pronto` timing**: `pronto` falls in the same cycle `ocupacao` reaches PROFUNDIDADE. It rises in the cycle after the pop edge.
- **Reset mid-byte**: remaining bits of the in-flight byte are dropped. After reset release, nothing is emitted until a new push.

## Test plan
- **Single byte**: push 0xA5 at edge 1 → `bit_out` = 1,0,1,0,0,1,0,1 after edges 2..9. `bit_valido`=1 exactly on those 8 cycles. `inicio`=1 only after edge 2. `bit_valido`=0 after edge 10.
- **Two bytes**: push 0xFF then 0x00 on consecutive edges → 16 contiguous valid bits (eight 1s, then eight 0s). `inicio` pulses once.
- **Full FIFO** (PROFUNDIDADE=4): hold `dado_valido`=1 with bytes 0x01..0x06 from edge 1.
  - Bytes 0x01–0x05 are accepted at edges 1–5.
  - `ocupacao`=4 and `pronto`=0 after edge 5.
  - 0x02 is popped at edge 10; `pronto`=1 after edge 10.
  - 0x06 is accepted at edge 11.
  - Output is 48 contiguous bits in order.
- **Idle gap**: push 0x80, wait 20 cycles, push 0x01.
  - Two separate 8-bit bursts, each with its own `inicio` pulse.
  - `bit_valido`=0 between the bursts.
- **Reset mid-operation**: push 0xC3 and 0x3C, then assert `rst` after the 3rd bit.
  - All outputs are 0 immediately (asynchronous).
  - `ocupacao`=0.
  - After release, no bits are emitted until a new push.
- **Write during reset**: `dado_valido`=1 while `rst`=1 → nothing stored. `ocupacao`=0 after release.

Source files
------------

// File: rtl/serializador_bits.sv
// serializador_bits: byte FIFO feeding an MSB-first bit serializer.
// Emits one bit per clock with a registered valid flag. A one-cycle
// `inicio` pulse marks the first bit of each contiguous burst.
module serializador_bits #(
  parameter int PROFUNDIDADE = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    dado_in,
  input  logic                          dado_valido,
  output logic                          pronto,
  output logic                          bit_out,
  output logic                          bit_valido,
  output logic                          inicio,
  output logic [$clog2(PROFUNDIDADE):0] ocupacao
);

  localparam int AW = $clog2(PROFUNDIDADE);
  localparam logic [AW:0]   OCUP_MAX = (AW+1)'(PROFUNDIDADE);
  localparam logic [AW:0]   OCUP_UM  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_UM   = AW'(1);

  typedef enum logic {OCIOSO, DESLOCA} estado_t;

  // FIFO storage and bookkeeping
  logic [7:0]    mem_q [PROFUNDIDADE];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   ocup_q, ocup_d;

  // Serializer state
  estado_t       estado_q;
  logic [7:0]    desl_q;
  logic [2:0]    cnt_q;
  logic          bit_out_q, bit_valido_q, inicio_q;

  logic          vazio, cheio, push, pop;
  logic [7:0]    cabeca;

  assign cheio  = (ocup_q == OCUP_MAX);
  assign vazio  = (ocup_q == '0);
  assign pronto = !cheio;
  assign push   = dado_valido && pronto;
  assign cabeca = mem_q[rd_ptr_q];

  // A byte leaves the FIFO when the shifter is idle, or when its last bit
  // is on the output, so consecutive bytes run with no gap. Because
  // ocupacao is registered, a freshly pushed byte cannot be popped at the
  // same edge it is written.
  assign pop = !vazio && ((estado_q == OCIOSO) || (cnt_q == 3'd0));

  assign bit_out    = bit_out_q;
  assign bit_valido = bit_valido_q;
  assign inicio     = inicio_q;
  assign ocupacao   = ocup_q;

  // Next-state for pointers and occupancy. A simultaneous push and pop
  // leaves the occupancy unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ocup_d   = ocup_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_UM;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_UM;
    case ({push, pop})
      2'b10:   ocup_d = ocup_q + OCUP_UM;
      2'b01:   ocup_d = ocup_q - OCUP_UM;
      default: ocup_d = ocup_q;
    endcase
  end

  // FIFO data array. It is not reset because the pointers define which
  // entries are meaningful. Writes are gated off while reset is high.
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= dado_in;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ocup_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ocup_q   <= ocup_d;
    end
  end

  // Serializer FSM with registered bit, valid and start outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q     <= OCIOSO;
      desl_q       <= '0;
      cnt_q        <= '0;
      bit_out_q    <= 1'b0;
      bit_valido_q <= 1'b0;
      inicio_q     <= 1'b0;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (!vazio) begin
            desl_q       <= cabeca;
            bit_out_q    <= cabeca[7];
            bit_valido_q <= 1'b1;
            inicio_q     <= 1'b1;
            cnt_q        <= 3'd7;
            estado_q     <= DESLOCA;
          end else begin
            bit_valido_q <= 1'b0;
            inicio_q     <= 1'b0;
          end
        end
        DESLOCA: begin
          inicio_q <= 1'b0;
          if (cnt_q != 3'd0) begin
            // bit_out already holds desl_q[7], so bit 6 is the next one out
            desl_q    <= {desl_q[6:0], 1'b0};
            bit_out_q <= desl_q[6];
            cnt_q     <= cnt_q - 3'd1;
          end else if (!vazio) begin
            // Back-to-back byte: the burst continues, so there is no new start pulse
            desl_q    <= cabeca;
            bit_out_q <= cabeca[7];
            cnt_q     <= 3'd7;
          end else begin
            bit_valido_q <= 1'b0;
            bit_out_q    <= 1'b0;
            estado_q     <= OCIOSO;
          end
        end
        default: estado_q <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_serializador_bits.sv
// Directed testbench for serializador_bits (PROFUNDIDADE = 4).
module tb_serializador_bits;

  localparam int P = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] dado_in;
  logic       dado_valido;
  logic       pronto, bit_out, bit_valido, inicio;
  logic [2:0] ocupacao;

  serializador_bits #(.PROFUNDIDADE(P)) dut (
    .clk(clk), .rst(rst), .dado_in(dado_in), .dado_valido(dado_valido),
    .pronto(pronto), .bit_out(bit_out), .bit_valido(bit_valido),
    .inicio(inicio), .ocupacao(ocupacao)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output stream monitor, updated once per cycle
  bit q[$];
  int n_ini, n_rise, n_bad_ini;
  logic prev_v = 1'b0;

  task automatic clr();
    q.delete();
    n_ini = 0; n_rise = 0; n_bad_ini = 0;
  endtask

  // Advance past the next rising edge, then sample the outputs
  task automatic tick();
    @(posedge clk);
    #1;
    if (bit_valido) q.push_back(bit_out);
    if (inicio) n_ini++;
    if (inicio && !bit_valido) n_bad_ini++;
    if (bit_valido && !prev_v) n_rise++;
    prev_v = bit_valido;
  endtask

  task automatic push(input logic [7:0] b);
    dado_in = b;
    dado_valido = 1'b1;
    tick();
    dado_valido = 1'b0;
  endtask

  // Compare the captured stream against nbytes bytes packed MSB-first in v
  task automatic chk_stream(input string tag, input logic [63:0] v, input int nbytes);
    int mism = 0;
    chk({tag, "_len"}, q.size(), 8 * nbytes);
    for (int k = 0; k < q.size() && k < 8 * nbytes; k++)
      if (q[k] !== v[8*nbytes-1-k]) mism++;
    chk({tag, "_bits"}, mism, 0);
  endtask

  initial begin
    int e, acc_edge;
    logic [7:0] b;
    logic acc;
    rst = 1'b1; dado_valido = 1'b0; dado_in = 8'h00;
    clr();
    #3;
    chk("rst_bit_out", bit_out, 0);
    chk("rst_valido", bit_valido, 0);
    chk("rst_inicio", inicio, 0);
    chk("rst_pronto", pronto, 1);
    chk("rst_ocup", ocupacao, 0);
    tick();
    rst = 1'b0;
    tick();

    // Single byte: 0xA5 pushed at edge 1, bits after edges 2..9
    clr();
    push(8'hA5);
    chk("a5_ocup_e1", ocupacao, 1);
    chk("a5_nobypass", bit_valido, 0);
    tick();
    chk("a5_ini_e2", inicio, 1);
    chk("a5_bit_e2", bit_out, 1);
    chk("a5_ocup_e2", ocupacao, 0);
    repeat (7) tick();
    chk("a5_valid_e9", bit_valido, 1);
    tick();
    chk("a5_valid_e10", bit_valido, 0);
    chk_stream("a5", 64'hA5, 1);
    chk("a5_ini_cnt", n_ini, 1);

    // Two bytes back-to-back
    tick(); clr();
    push(8'hFF);
    push(8'h00);
    repeat (18) tick();
    chk_stream("ff00", 64'hFF00, 2);
    chk("ff00_ini", n_ini, 1);
    chk("ff00_rise", n_rise, 1);

    // Full FIFO: hold valid with 0x01..0x06
    clr();
    b = 8'h01; dado_valido = 1'b1; e = 0; acc_edge = 0;
    for (int i = 0; i < 60; i++) begin
      dado_in = b;
      acc = pronto && dado_valido;
      tick();
      e++;
      if (acc) begin
        if (b == 8'h06) acc_edge = e;
        b = b + 8'h01;
        if (b == 8'h07) dado_valido = 1'b0;
      end
      if (e == 5) begin
        chk("full_ocup_e5", ocupacao, 4);
        chk("full_pronto_e5", pronto, 0);
      end
      if (e == 9)  chk("full_pronto_e9", pronto, 0);
      if (e == 10) chk("full_pronto_e10", pronto, 1);
    end
    chk("full_acc06_edge", acc_edge, 11);
    chk_stream("full", 64'h010203040506, 6);
    chk("full_rise", n_rise, 1);
    chk("full_ini", n_ini, 1);

    // Idle gap between two bytes
    clr();
    push(8'h80);
    repeat (20) tick();
    push(8'h01);
    repeat (12) tick();
    chk_stream("gap", 64'h8001, 2);
    chk("gap_rise", n_rise, 2);
    chk("gap_ini", n_ini, 2);

    // Reset mid-byte after the third bit, plus a write while in reset
    clr();
    push(8'hC3);
    push(8'h3C);
    tick(); tick();
    chk("mid_bits_before_rst", q.size(), 3);
    rst = 1'b1;
    #1;
    chk("mid_rst_valido", bit_valido, 0);
    chk("mid_rst_bit", bit_out, 0);
    chk("mid_rst_inicio", inicio, 0);
    chk("mid_rst_ocup", ocupacao, 0);
    chk("mid_rst_pronto", pronto, 1);
    dado_in = 8'h77; dado_valido = 1'b1;
    tick(); tick();
    chk("wr_in_rst_ocup", ocupacao, 0);
    #2;
    rst = 1'b0; dado_valido = 1'b0;
    clr();
    repeat (12) tick();
    chk("post_rst_silent", q.size(), 0);
    chk("post_rst_ocup", ocupacao, 0);
    push(8'h5A);
    repeat (10) tick();
    chk_stream("post_rst", 64'h5A, 1);
    chk("post_rst_ini", n_ini, 1);

    chk("inicio_without_valid", n_bad_ini, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
